// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared datapath constants and types for the 8-bit CPU.
//   DATA_WIDTH     : width of a datapath word / register
//   REG_ADDR_WIDTH : width of a register-file index
//   reg_idx_t      : register index type
//   data_t         : datapath word type
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int REG_ADDR_WIDTH = 2;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

endpackage : cpu_pkg

// File: rtl/regfile_read_mux.sv
// ---------------------------------------------------------------------------
// regfile_read_mux
// Purely combinational read port: selects one entry of the register array.
// An X index propagates to an X output; no sanitisation is done here.
// Ports:
//   i_regs : register array contents (NUM_ENTRIES x WIDTH)
//   i_idx  : entry index
//   o_data : selected entry
// ---------------------------------------------------------------------------
module regfile_read_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH       = DATA_WIDTH,
    parameter int IDX_WIDTH   = REG_ADDR_WIDTH,
    parameter int NUM_ENTRIES = 1 << IDX_WIDTH
) (
    input  logic [WIDTH-1:0]     i_regs [NUM_ENTRIES],
    input  logic [IDX_WIDTH-1:0] i_idx,
    output logic [WIDTH-1:0]     o_data
);

    assign o_data = i_regs[i_idx];

endmodule : regfile_read_mux

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// General-purpose register file for the 8-bit CPU datapath: NUM_REGS
// registers, two combinational read ports, one synchronous write port.
// Every register (including 0) is writable; there is no hard-wired zero.
// Ports:
//   clk             : system clock, state updates on rising edge
//   reset           : asynchronous active-low reset, clears all registers
//   RegWrite_Enable : write strobe sampled on rising clk
//   RegisterData1   : read-port-1 index
//   RegisterData2   : read-port-2 index
//   WriteRegister   : write-port index
//   WriteData       : write data
//   Data1           : contents of reg[RegisterData1]
//   Data2           : contents of reg[RegisterData2]
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite_Enable,
    input  logic [ADDR_WIDTH-1:0] RegisterData1,
    input  logic [ADDR_WIDTH-1:0] RegisterData2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2
);

    // The index width must address exactly NUM_REGS entries.
    if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_bad_size
        $error("register_file: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Reset dominates: a write strobe while reset is low is discarded.
    // Reads are unbypassed, so a same-index read shows the new value only
    // after the write edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (RegWrite_Enable) begin
            r_regs[WriteRegister] <= WriteData;
        end
    end

    regfile_read_mux #(
        .WIDTH       (DATA_WIDTH),
        .IDX_WIDTH   (ADDR_WIDTH),
        .NUM_ENTRIES (NUM_REGS)
    ) u_read_mux_1 (
        .i_regs (r_regs),
        .i_idx  (RegisterData1),
        .o_data (Data1)
    );

    regfile_read_mux #(
        .WIDTH       (DATA_WIDTH),
        .IDX_WIDTH   (ADDR_WIDTH),
        .NUM_ENTRIES (NUM_REGS)
    ) u_read_mux_2 (
        .i_regs (r_regs),
        .i_idx  (RegisterData2),
        .o_data (Data2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Directed steps followed by randomized traffic, checked against an
// array-based model of the register file.
// ---------------------------------------------------------------------------
module tb_register_file;

    logic       clk;
    logic       reset;
    logic       RegWrite_Enable;
    logic [1:0] RegisterData1;
    logic [1:0] RegisterData2;
    logic [1:0] WriteRegister;
    logic [7:0] WriteData;
    logic [7:0] Data1;
    logic [7:0] Data2;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of register contents.
    logic [7:0] model [4];

    register_file dut (
        .clk             (clk),
        .reset           (reset),
        .RegWrite_Enable (RegWrite_Enable),
        .RegisterData1   (RegisterData1),
        .RegisterData2   (RegisterData2),
        .WriteRegister   (WriteRegister),
        .WriteData       (WriteData),
        .Data1           (Data1),
        .Data2           (Data2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic void model_clear();
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set both read indices, let the combinational path settle, compare.
    task automatic check_read(input string tag, input logic [1:0] a1, input logic [1:0] a2);
        RegisterData1 = a1;
        RegisterData2 = a2;
        #1;
        check({tag, "_d1"}, Data1, model[a1]);
        check({tag, "_d2"}, Data2, model[a2]);
    endtask

    // One clock edge with the given write request, model updated at the edge.
    task automatic write_reg(input logic en, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        RegWrite_Enable = en;
        WriteRegister   = a;
        WriteData       = d;
        @(posedge clk);
        if (reset && en) model[a] = d;
        #1;
        RegWrite_Enable = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] a1, a2, wa;
        logic [7:0] wd;
        logic       we;

        reset           = 1'b0;
        RegWrite_Enable = 1'b0;
        RegisterData1   = '0;
        RegisterData2   = '0;
        WriteRegister   = '0;
        WriteData       = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;

        // Reset state: every register reads zero through both ports.
        for (int i = 0; i < 4; i++) check_read("reset_state", 2'(i), 2'(3 - i));

        @(negedge clk);
        reset = 1'b1;

        // 1. Reset clears asynchronously between clock edges.
        write_reg(1'b1, 2'd2, 8'hA5);
        check_read("t1_written", 2'd2, 2'd2);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        check("t1_async_clear", Data1, 8'h00);
        #1;
        reset = 1'b1;

        // 2. Disabled write changes nothing.
        write_reg(1'b0, 2'd0, 8'hFF);
        check_read("t2_r0_r1", 2'd0, 2'd1);
        check_read("t2_r3", 2'd3, 2'd3);
        check("t2_r0_const", Data1 | model[0], 8'h00);

        // 3. Basic write then read.
        write_reg(1'b1, 2'd0, 8'h01);
        check_read("t3", 2'd0, 2'd3);
        check("t3_d1_const", Data1, 8'h01);
        check("t3_d2_const", Data2, 8'h00);

        // 4. Fill all registers, sweep both ports.
        write_reg(1'b1, 2'd0, 8'h11);
        write_reg(1'b1, 2'd1, 8'h22);
        write_reg(1'b1, 2'd2, 8'h33);
        write_reg(1'b1, 2'd3, 8'h44);
        for (int i = 0; i < 4; i++) begin
            check_read("t4_sweep", 2'(i), 2'(3 - i));
            check("t4_d1_const", Data1, 8'(8'h11 * (i + 1)));
        end
        for (int i = 0; i < 4; i++) begin
            check_read("t4_same", 2'(i), 2'(i));
            check("t4_agree", Data1, Data2);
        end

        // 5. Read-during-write: old value before the edge, new one after.
        write_reg(1'b1, 2'd1, 8'h10);
        RegisterData1 = 2'd1;
        @(negedge clk);
        RegWrite_Enable = 1'b1;
        WriteRegister   = 2'd1;
        WriteData       = 8'h20;
        #1;
        check("t5_before_edge", Data1, 8'h10);
        @(posedge clk);
        model[1] = 8'h20;
        #1;
        check("t5_after_edge", Data1, 8'h20);
        RegWrite_Enable = 1'b0;

        // 6. Write blocked while reset is held low.
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        write_reg(1'b1, 2'd3, 8'h7E);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_read("t6_r3", 2'd3, 2'd0);
        check("t6_r3_const", Data1, 8'h00);

        // Randomized traffic with occasional reset pulses.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = 2'($urandom_range(0, 3));
            wd = 8'($urandom);
            a1 = 2'($urandom_range(0, 3));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 24) != 0);
            if (!reset) model_clear();
            RegWrite_Enable = we;
            WriteRegister   = wa;
            WriteData       = wd;
            check_read("rnd_pre", a1, a2);
            @(posedge clk);
            if (reset && we) model[wa] = wd;
            #1;
            check("rnd_post_d1", Data1, model[a1]);
            check("rnd_post_d2", Data2, model[a2]);
        end
        @(negedge clk);
        RegWrite_Enable = 1'b0;
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_file
